obi_spm_bank_arbiter: RTL and testbench

// - OBI slave sitting directly downstream of the dcache-to-OBI bridge. Terminates NUM_PORTS OBI master

---
 rtl/obi_spm_bank_arbiter.sv | 155 +++++++++++++++
 tb/tb_obi_spm_bank_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_spm_bank_arbiter.sv
// obi_spm_bank_arbiter: NUM_PORTS OBI slave ports round-robin arbitrated onto one
// single-port, word-wide scratchpad bank. At most one transfer is accepted per cycle,
// and its response returns on the granted lane exactly one cycle later.
// Optional feature macro OBI_SPM_ADDR_CHECK_EN: range-check the address against
// [BASE_ADDR, BASE_ADDR+DEPTH*4), drop out-of-range writes, answer out-of-range
// reads with 32'hDEAD_BEEF and raise a sticky err_o. Without it, addresses alias
// modulo the bank size and there is no err_o port.
module obi_spm_bank_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_PORTS-1:0]    req_i,
    input  logic [NUM_PORTS-1:0]    we_i,
    input  logic [NUM_PORTS*4-1:0]  be_i,
    input  logic [NUM_PORTS*32-1:0] addr_i,
    input  logic [NUM_PORTS*32-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]    gnt_o,
    output logic [NUM_PORTS-1:0]    rvalid_o,
    output logic [NUM_PORTS*32-1:0] rdata_o
`ifdef OBI_SPM_ADDR_CHECK_EN
    ,
    output logic                   err_o
`endif
);

    localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [31:0] BANK_BYTES = 32'(DEPTH * 4);
    localparam logic [31:0] ERR_WORD   = 32'hDEAD_BEEF;

    // What the response lane carries in the cycle after a transfer.
    typedef enum logic [1:0] {
        RESP_READ  = 2'd0,
        RESP_WRITE = 2'd1,
        RESP_ERR   = 2'd2
    } resp_kind_e;

    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
    resp_kind_e           resp_kind_q, resp_kind_d;
    logic                 err_q, err_d;

    logic                 gnt_valid;
    logic [PTR_W-1:0]     gnt_idx;
    logic                 sel_we;
    logic [3:0]           sel_be;
    logic [31:0]          sel_wdata;
    logic [31:0]          sel_offset;
    logic [IDX_W-1:0]     mem_idx;
    logic                 in_range;
    logic                 mem_wr_en;
    logic                 mem_rd_en;

    logic [31:0]          mem_q [DEPTH];
    logic [31:0]          rd_word_q;

    // Round-robin search starting at the pointer; no grants while reset is held.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output a default
        // first, so no path through the block leaves a value held (no latch).
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        gnt_o     = '0;
        if (rst_ni) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (!gnt_valid && req_i[(32'(ptr_q) + i) % NUM_PORTS]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = PTR_W'((32'(ptr_q) + i) % NUM_PORTS);
                end
            end
        end
        if (gnt_valid) begin
            gnt_o[gnt_idx] = 1'b1;
        end
    end

    // Decode the granted port's attributes and compute next-state for the control flops.
    always_comb begin
        sel_we     = we_i[gnt_idx];
        sel_be     = be_i[4*gnt_idx +: 4];
        sel_wdata  = wdata_i[32*gnt_idx +: 32];
        sel_offset = addr_i[32*gnt_idx +: 32] - BASE_ADDR;
        mem_idx    = IDX_W'(sel_offset >> 2);
`ifdef OBI_SPM_ADDR_CHECK_EN
        in_range   = (sel_offset < BANK_BYTES);
`else
        in_range   = 1'b1;
`endif
        mem_wr_en  = gnt_valid & sel_we & in_range;
        mem_rd_en  = gnt_valid & ~sel_we;

        ptr_d       = ptr_q;
        rvalid_d    = gnt_o;
        resp_kind_d = sel_we ? RESP_WRITE : (in_range ? RESP_READ : RESP_ERR);
        err_d       = err_q | (gnt_valid & ~in_range);
        if (gnt_valid) begin
            ptr_d = (32'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Control state: pointer, pending response and sticky error, synchronously reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential blocks use non-blocking '<=' so every flop samples pre-edge values.
        if (!rst_ni) begin
            ptr_q       <= '0;
            rvalid_q    <= '0;
            resp_kind_q <= RESP_READ;
            err_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            rvalid_q    <= rvalid_d;
            resp_kind_q <= resp_kind_d;
            err_q       <= err_d;
        end
    end

    // Bank access on the transfer edge: byte-masked write or registered full-word read.
    always_ff @(posedge clk_i) begin
        // NOTE: the bank and its read register are deliberately not reset; the storage is
        // RAM, and a stale read word is never visible because rvalid gates the lane.
        if (mem_rd_en) begin
            rd_word_q <= mem_q[mem_idx];
        end
        if (mem_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_be[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= sel_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response lanes: only the lane with rvalid carries data; asserting reset drops it at once.
    always_comb begin
        rvalid_o = rst_ni ? rvalid_q : '0;
        rdata_o  = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (rvalid_o[p]) begin
                case (resp_kind_q)
                    RESP_READ: rdata_o[32*p +: 32] = rd_word_q;
                    RESP_ERR:  rdata_o[32*p +: 32] = ERR_WORD;
                    default:   rdata_o[32*p +: 32] = '0;
                endcase
            end
        end
    end

`ifdef OBI_SPM_ADDR_CHECK_EN
    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_obi_spm_bank_arbiter.sv
// Self-checking bench for obi_spm_bank_arbiter. A behavioural model (word array, RR
// pointer as an integer, modulo search) predicts grant, response and data each cycle.
// Builds with or without OBI_SPM_ADDR_CHECK_EN.
module tb_obi_spm_bank_arbiter;

    localparam int          NP   = 4;
    localparam int          DEP  = 64;
    localparam logic [31:0] BASE = 32'h0000_4000;
`ifdef OBI_SPM_ADDR_CHECK_EN
    localparam bit          CHK  = 1'b1;
`else
    localparam bit          CHK  = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NP-1:0]     req_i;
    logic [NP-1:0]     we_i;
    logic [NP*4-1:0]   be_i;
    logic [NP*32-1:0]  addr_i;
    logic [NP*32-1:0]  wdata_i;
    logic [NP-1:0]     gnt_o;
    logic [NP-1:0]     rvalid_o;
    logic [NP*32-1:0]  rdata_o;
`ifdef OBI_SPM_ADDR_CHECK_EN
    logic              err_o;
`endif

    obi_spm_bank_arbiter #(
        .NUM_PORTS (NP),
        .DEPTH     (DEP),
        .BASE_ADDR (BASE)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .we_i     (we_i),
        .be_i     (be_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o)
`ifdef OBI_SPM_ADDR_CHECK_EN
        ,
        .err_o    (err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int            n_vec = 0;
    int            n_err = 0;
    logic [31:0]   mdl_mem [DEP];
    int            mdl_ptr = 0;
    bit            mdl_err = 1'b0;
    logic [NP-1:0] gnt_seen;

    task automatic clear_inputs();
        req_i   = '0;
        we_i    = '0;
        be_i    = '0;
        addr_i  = '0;
        wdata_i = '0;
    endtask

    task automatic drive(input int p, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_i[p]          = 1'b1;
        we_i[p]           = we;
        be_i[4*p +: 4]    = be;
        addr_i[32*p +: 32] = addr;
        wdata_i[32*p +: 32] = wdata;
    endtask

    // One clock: predict from the model, compare gnt at negedge, response after posedge.
    task automatic cycle(input bit chk_resp, output int g);
        logic [NP-1:0]    eg;
        logic [NP-1:0]    erv;
        logic [NP*32-1:0] erd;
        logic [31:0]      off;
        int               w;
        bit               oor;
        eg  = '0;
        erv = '0;
        erd = '0;
        g   = -1;
        if (rst_ni === 1'b1) begin
            for (int i = 0; i < NP; i++) begin
                if (g < 0 && req_i[(mdl_ptr + i) % NP]) g = (mdl_ptr + i) % NP;
            end
        end
        if (g >= 0) begin
            eg[g]  = 1'b1;
            erv[g] = 1'b1;
            off = addr_i[32*g +: 32] - BASE;
            w   = int'(off >> 2) % DEP;
            oor = CHK && (off >= 32'(DEP * 4));
            if (we_i[g]) begin
                if (!oor) begin
                    for (int b = 0; b < 4; b++)
                        if (be_i[4*g + b]) mdl_mem[w][8*b +: 8] = wdata_i[32*g + 8*b +: 8];
                end
            end else begin
                erd[32*g +: 32] = oor ? 32'hDEAD_BEEF : mdl_mem[w];
            end
            if (oor) mdl_err = 1'b1;
            mdl_ptr = (g + 1) % NP;
        end
        if (rst_ni !== 1'b1) begin
            mdl_ptr = 0;
            mdl_err = 1'b0;
        end
        @(negedge clk_i);
        gnt_seen = gnt_o;
        n_vec++;
        if (gnt_o !== eg) begin
            n_err++;
            $display("FAIL gnt: got %b expected %b", gnt_o, eg);
        end
        @(posedge clk_i);
        #1;
        if (chk_resp) begin
            n_vec++;
            if (rvalid_o !== erv) begin
                n_err++;
                $display("FAIL rvalid: got %b expected %b", rvalid_o, erv);
            end
            n_vec++;
            if (rdata_o !== erd) begin
                n_err++;
                $display("FAIL rdata: got %h expected %h", rdata_o, erd);
            end
`ifdef OBI_SPM_ADDR_CHECK_EN
            n_vec++;
            if (err_o !== mdl_err) begin
                n_err++;
                $display("FAIL err_o: got %b expected %b", err_o, mdl_err);
            end
`endif
        end
    endtask

    task automatic test_reset();
        int g;
        rst_ni = 1'b0;
        clear_inputs();
        req_i  = '1;
        addr_i = {$urandom, $urandom, $urandom, $urandom};
        repeat (2) cycle(1'b1, g);
        rst_ni = 1'b1;
        clear_inputs();
        cycle(1'b1, g);
    endtask

    task automatic test_fill();
        int g;
        for (int w = 0; w < DEP; w++) begin
            clear_inputs();
            drive(0, 1'b1, 4'hF, BASE + 32'(4 * w), $urandom);
            cycle(1'b1, g);
        end
        clear_inputs();
    endtask

    task automatic test_single_read();
        int g;
        clear_inputs();
        drive(0, 1'b1, 4'hF, BASE + 32'h10, 32'hCAFE_F00D);
        cycle(1'b1, g);
        clear_inputs();
        drive(0, 1'b0, 4'h0, BASE + 32'h10, 32'h0);
        cycle(1'b1, g);
        n_vec++;
        if (rdata_o[31:0] !== 32'hCAFE_F00D || rvalid_o !== 4'b0001) begin
            n_err++;
            $display("FAIL single_read: got %h/%b expected cafef00d/0001", rdata_o[31:0], rvalid_o);
        end
        clear_inputs();
    endtask

    task automatic test_partial_write();
        int g;
        clear_inputs();
        drive(2, 1'b1, 4'hF, BASE + 32'h24, 32'h1122_3344);
        cycle(1'b1, g);
        clear_inputs();
        drive(2, 1'b1, 4'b0101, BASE + 32'h24, 32'hAABB_CCDD);
        cycle(1'b1, g);
        clear_inputs();
        drive(2, 1'b0, 4'hF, BASE + 32'h24, 32'h0);
        cycle(1'b1, g);
        n_vec++;
        if (rdata_o[95:64] !== 32'h11BB_33DD) begin
            n_err++;
            $display("FAIL partial_write: got %h expected 11bb33dd", rdata_o[95:64]);
        end
        clear_inputs();
    endtask

    task automatic test_contention();
        int g;
        clear_inputs();
        drive(3, 1'b0, 4'hF, BASE, 32'h0);   // leaves the pointer at 0
        cycle(1'b1, g);
        clear_inputs();
        for (int p = 0; p < NP; p++) drive(p, 1'b0, 4'hF, BASE + 32'(4 * (p + 1)), 32'h0);
        for (int k = 0; k < NP; k++) begin
            cycle(1'b1, g);
            n_vec++;
            if (gnt_seen !== NP'(1 << k)) begin
                n_err++;
                $display("FAIL contention_order: got %b expected %b", gnt_seen, NP'(1 << k));
            end
            if (g >= 0) req_i[g] = 1'b0;
        end
        // Pointer wrapped to 0: p0 beats p3.
        clear_inputs();
        drive(0, 1'b0, 4'hF, BASE, 32'h0);
        drive(3, 1'b0, 4'hF, BASE + 32'h8, 32'h0);
        cycle(1'b1, g);
        n_vec++;
        if (gnt_seen !== 4'b0001) begin
            n_err++;
            $display("FAIL contention_ptr_wrap: got %b expected 0001", gnt_seen);
        end
        clear_inputs();
    endtask

    task automatic test_fairness();
        int          g;
        logic [3:0]  exp_g;
        clear_inputs();
        for (int c = 0; c < 10; c++) begin
            drive(1, 1'b0, 4'hF, BASE + 32'(4 * $urandom_range(0, DEP - 1)), 32'h0);
            if (c >= 3) drive(2, 1'b0, 4'hF, BASE + 32'h40, 32'h0);
            cycle(1'b1, g);
            exp_g = (c >= 3 && (c % 2) == 1) ? 4'b0100 : 4'b0010;
            n_vec++;
            if (gnt_seen !== exp_g) begin
                n_err++;
                $display("FAIL fairness_c%0d: got %b expected %b", c, gnt_seen, exp_g);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        int g;
        clear_inputs();
        drive(2, 1'b0, 4'hF, BASE + 32'h8, 32'h0);
        cycle(1'b0, g);
        clear_inputs();
        rst_ni = 1'b0;
        #1;
        n_vec++;
        if (rvalid_o !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_mid_rvalid: got %b expected 0000", rvalid_o);
        end
        cycle(1'b1, g);
        rst_ni = 1'b1;
        drive(1, 1'b0, 4'hF, BASE + 32'h4, 32'h0);
        drive(3, 1'b0, 4'hF, BASE + 32'hC, 32'h0);
        cycle(1'b1, g);
        n_vec++;
        if (gnt_seen !== 4'b0010) begin
            n_err++;
            $display("FAIL reset_mid_ptr: got %b expected 0010", gnt_seen);
        end
        clear_inputs();
    endtask

`ifdef OBI_SPM_ADDR_CHECK_EN
    task automatic test_addr_check();
        int g;
        clear_inputs();
        drive(0, 1'b1, 4'hF, BASE + 32'h30, 32'h0BAD_F00D);
        cycle(1'b1, g);
        clear_inputs();
        drive(1, 1'b0, 4'hF, BASE + 32'(DEP * 4), 32'h0);
        cycle(1'b1, g);
        n_vec++;
        if (rdata_o[63:32] !== 32'hDEAD_BEEF || err_o !== 1'b1 || rvalid_o !== 4'b0010) begin
            n_err++;
            $display("FAIL addr_check_read: got %h/%b/%b expected deadbeef/1/0010",
                     rdata_o[63:32], err_o, rvalid_o);
        end
        clear_inputs();
        drive(0, 1'b1, 4'hF, BASE + 32'(DEP * 4) + 32'h30, 32'h1234_5678);
        cycle(1'b1, g);
        clear_inputs();
        drive(0, 1'b0, 4'hF, BASE + 32'h30, 32'h0);
        cycle(1'b1, g);
        n_vec++;
        if (rdata_o[31:0] !== 32'h0BAD_F00D) begin
            n_err++;
            $display("FAIL addr_check_bank_kept: got %h expected 0badf00d", rdata_o[31:0]);
        end
        clear_inputs();
    endtask
`else
    task automatic test_wrap();
        int g;
        clear_inputs();
        drive(0, 1'b1, 4'hF, BASE + 32'(DEP * 4) + 32'hC, 32'h5A5A_1234);
        cycle(1'b1, g);
        clear_inputs();
        drive(1, 1'b0, 4'hF, BASE + 32'hC, 32'h0);
        cycle(1'b1, g);
        n_vec++;
        if (rdata_o[63:32] !== 32'h5A5A_1234) begin
            n_err++;
            $display("FAIL wrap_alias: got %h expected 5a5a1234", rdata_o[63:32]);
        end
        clear_inputs();
    endtask
`endif

    // Random traffic; each master holds its request and attributes until granted.
    task automatic test_random();
        int          g;
        logic [31:0] a;
        clear_inputs();
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (!req_i[p] && $urandom_range(0, 1) == 1) begin
                    a = BASE + 32'(4 * $urandom_range(0, DEP - 1)) + 32'($urandom_range(0, 3));
                    if ($urandom_range(0, 7) == 0) a = a + 32'(DEP * 4 * $urandom_range(1, 3));
                    drive(p, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom);
                end
            end
            cycle(1'b1, g);
            if (g >= 0) req_i[g] = 1'b0;
        end
        clear_inputs();
        cycle(1'b1, g);
    endtask

    initial begin
        rst_ni = 1'b0;
        clear_inputs();
        @(posedge clk_i);
        #1;
        test_reset();
        test_fill();
        test_single_read();
        test_partial_write();
        test_contention();
        test_fairness();
        test_reset_mid();
`ifdef OBI_SPM_ADDR_CHECK_EN
        test_addr_check();
`else
        test_wrap();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
